// File: rtl/vlsu_mem_arb.sv
// -----------------------------------------------------------------------------
// vlsu_mem_arb
//
// Arbitrates two vector memory clients onto one shared X-IF memory request
// port, and routes X-IF memory results back to the client that issued the
// matching transaction ID.
//
//   requester 0 : vector load/store unit
//   requester 1 : secondary vector memory client
//
// Ports
//   clk_i                  single clock, all state on the rising edge
//   rst_ni                 synchronous active-low reset
//   req_valid_i[1:0]       per-requester request valid
//   req_ready_o[1:0]       per-requester request accepted
//   req_i[1:0]             per-requester request payload
//   req_lock_i[1:0]        per-requester burst lock (VLSU_ARB_LOCK_EN only)
//   xif_mem_valid_o        shared X-IF request valid
//   xif_mem_ready_i        shared X-IF request ready
//   xif_mem_req_o          shared X-IF request payload
//   xif_mem_result_valid_i shared X-IF result valid
//   xif_mem_result_i       shared X-IF result payload
//   res_valid_o[1:0]       routed result valid, one bit per requester
//   res_o[1:0]             result payload, forwarded to both requesters
//   err_orphan_o           pulse: result for an ID with no outstanding entry
//   dbg_state_o            current arbiter FSM state (debug/observability)
//
// Handshake semantics: a transfer happens on a rising edge where valid and
// ready are both high. A granted requester keeps the grant while
// xif_mem_valid_o is high and xif_mem_ready_i is low, so the X-IF payload is
// stable until accepted. Ready may depend combinationally on valid.
//
// Configuration
//   VLSU_ARB_LOCK_EN  when defined, adds req_lock_i. A handshake with the
//                     lock bit set keeps the grant on that requester until a
//                     handshake with the lock bit clear (burst without
//                     interleave). Undefined: plain per-beat round robin.
//
// The ID width of the payload structs is fixed in vlsu_mem_arb_pkg; the
// X_ID_WIDTH parameter must match it.
// -----------------------------------------------------------------------------

package vlsu_mem_arb_pkg;

    localparam int unsigned XID_W = 4;

    typedef struct packed {
        logic [XID_W-1:0] id;
        logic [31:0]      addr;
        logic [1:0]       mode;
        logic             we;
        logic [3:0]       be;
        logic [31:0]      wdata;
    } x_mem_req_t;

    typedef struct packed {
        logic [XID_W-1:0] id;
        logic [31:0]      rdata;
        logic             err;
    } x_mem_result_t;

    typedef enum logic [1:0] {
        ST_ARB   = 2'd0,
        ST_HOLD0 = 2'd1,
        ST_HOLD1 = 2'd2
    } arb_state_e;

endpackage

module vlsu_mem_arb
    import vlsu_mem_arb_pkg::*;
#(
    parameter int unsigned X_ID_WIDTH = vlsu_mem_arb_pkg::XID_W,
    parameter int unsigned NUM_REQ    = 2
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,

    input  logic          [NUM_REQ-1:0]       req_valid_i,
    output logic          [NUM_REQ-1:0]       req_ready_o,
    input  x_mem_req_t    [NUM_REQ-1:0]       req_i,
`ifdef VLSU_ARB_LOCK_EN
    input  logic          [NUM_REQ-1:0]       req_lock_i,
`endif

    output logic                              xif_mem_valid_o,
    input  logic                              xif_mem_ready_i,
    output x_mem_req_t                        xif_mem_req_o,

    input  logic                              xif_mem_result_valid_i,
    input  x_mem_result_t                     xif_mem_result_i,

    output logic          [NUM_REQ-1:0]       res_valid_o,
    output x_mem_result_t [NUM_REQ-1:0]       res_o,
    output logic                              err_orphan_o,

    output logic          [1:0]               dbg_state_o
);

    localparam int unsigned DEPTH = 2 ** X_ID_WIDTH;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    arb_state_e       state_q, state_d;
    logic             rr_q, rr_d;                   // round-robin pointer
    logic [DEPTH-1:0] owner_valid_q, owner_valid_d; // ID outstanding
    logic [DEPTH-1:0] owner_who_q, owner_who_d;     // requester that owns ID

    // -------------------------------------------------------------------------
    // Burst lock
    // -------------------------------------------------------------------------
    logic [NUM_REQ-1:0] lock;

`ifdef VLSU_ARB_LOCK_EN
    assign lock = req_lock_i;
`else
    assign lock = '0;
`endif

    // -------------------------------------------------------------------------
    // Eligibility: a request whose ID is still outstanding is held back so
    // that a result can always be routed unambiguously by ID.
    // -------------------------------------------------------------------------
    logic [NUM_REQ-1:0] elig;

    always_comb begin
        elig = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            elig[i] = req_valid_i[i] && !owner_valid_q[req_i[i].id];
        end
    end

    // -------------------------------------------------------------------------
    // Grant and next state
    // -------------------------------------------------------------------------
    logic gnt_valid;
    logic gnt_idx;
    logic hs;

    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = 1'b0;

        // Outputs are forced idle while reset is asserted.
        if (rst_ni) begin
            unique case (state_q)
                ST_ARB: begin
                    if (elig[0] && elig[1]) begin
                        gnt_valid = 1'b1;
                        gnt_idx   = rr_q;
                    end else if (elig[0]) begin
                        gnt_valid = 1'b1;
                        gnt_idx   = 1'b0;
                    end else if (elig[1]) begin
                        gnt_valid = 1'b1;
                        gnt_idx   = 1'b1;
                    end
                end
                // While holding, the other requester is ignored entirely.
                // A hazard on the held requester (possible between locked
                // beats) simply stalls it without giving up the grant.
                ST_HOLD0: begin
                    if (elig[0]) begin
                        gnt_valid = 1'b1;
                        gnt_idx   = 1'b0;
                    end
                end
                ST_HOLD1: begin
                    if (elig[1]) begin
                        gnt_valid = 1'b1;
                        gnt_idx   = 1'b1;
                    end
                end
                default: begin
                    gnt_valid = 1'b0;
                end
            endcase
        end
    end

    assign hs = gnt_valid && xif_mem_ready_i;

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;

        unique case (state_q)
            ST_ARB: begin
                // Hold when the beat stalls, or when it is accepted but the
                // requester wants the grant for its next beat as well.
                if (gnt_valid && (!xif_mem_ready_i || lock[gnt_idx])) begin
                    state_d = gnt_idx ? ST_HOLD1 : ST_HOLD0;
                end
            end
            ST_HOLD0: begin
                // Dropping valid while held is tolerated: just release.
                if (!req_valid_i[0]) begin
                    state_d = ST_ARB;
                end else if (hs && !lock[0]) begin
                    state_d = ST_ARB;
                end
            end
            ST_HOLD1: begin
                if (!req_valid_i[1]) begin
                    state_d = ST_ARB;
                end else if (hs && !lock[1]) begin
                    state_d = ST_ARB;
                end
            end
            default: begin
                state_d = ST_ARB;
            end
        endcase

        // Pointer moves only when the requester gives up the port, so a
        // locked burst counts as a single turn.
        if (hs && !lock[gnt_idx]) begin
            rr_d = ~gnt_idx;
        end
    end

    // -------------------------------------------------------------------------
    // Request port outputs
    // -------------------------------------------------------------------------
    always_comb begin
        xif_mem_valid_o = gnt_valid;
        xif_mem_req_o   = '0;
        req_ready_o     = '0;
        if (gnt_valid) begin
            xif_mem_req_o        = req_i[gnt_idx];
            req_ready_o[gnt_idx] = xif_mem_ready_i;
        end
    end

    // -------------------------------------------------------------------------
    // Result routing and owner table update
    // -------------------------------------------------------------------------
    logic [X_ID_WIDTH-1:0] res_id;
    logic                  res_hit;
    logic                  res_orphan;

    assign res_id     = xif_mem_result_i.id;
    assign res_hit    = rst_ni && xif_mem_result_valid_i &&  owner_valid_q[res_id];
    assign res_orphan = rst_ni && xif_mem_result_valid_i && !owner_valid_q[res_id];

    always_comb begin
        res_valid_o  = '0;
        err_orphan_o = res_orphan;
        for (int i = 0; i < NUM_REQ; i++) begin
            res_o[i] = xif_mem_result_i;
        end
        if (res_hit) begin
            res_valid_o[owner_who_q[res_id]] = 1'b1;
        end
    end

    always_comb begin
        owner_valid_d = owner_valid_q;
        owner_who_d   = owner_who_q;

        if (res_hit) begin
            owner_valid_d[res_id] = 1'b0;
        end

        // Applied after the clear: a new issue of the same ID in the same
        // cycle must leave the entry valid with the new owner.
        if (hs) begin
            owner_valid_d[req_i[gnt_idx].id] = 1'b1;
            owner_who_d[req_i[gnt_idx].id]   = gnt_idx;
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q       <= ST_ARB;
            rr_q          <= 1'b0;
            owner_valid_q <= '0;
            owner_who_q   <= '0;
        end else begin
            state_q       <= state_d;
            rr_q          <= rr_d;
            owner_valid_q <= owner_valid_d;
            owner_who_q   <= owner_who_d;
        end
    end

    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_vlsu_mem_arb.sv
// -----------------------------------------------------------------------------
// tb_vlsu_mem_arb
//
// Inputs are driven 1 time unit after a rising edge, outputs are sampled
// 3 time units after it. Returned result data is tracked in an expected
// queue: pushed when a result that should be routed is driven, popped when
// the DUT raises a routed result valid.
// -----------------------------------------------------------------------------
module tb_vlsu_mem_arb;
    import vlsu_mem_arb_pkg::*;

    // ---------------------------------------------------------------- clock/reset
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // ---------------------------------------------------------------- DUT
    logic          [1:0] req_valid;
    logic          [1:0] req_ready;
    x_mem_req_t    [1:0] req;
`ifdef VLSU_ARB_LOCK_EN
    logic          [1:0] req_lock;
`endif
    logic                xif_valid;
    logic                xif_ready;
    x_mem_req_t          xif_req;
    logic                xres_valid;
    x_mem_result_t       xres;
    logic          [1:0] res_valid;
    x_mem_result_t [1:0] res;
    logic                orphan;
    logic          [1:0] dbg_state;

    vlsu_mem_arb #(.X_ID_WIDTH(4), .NUM_REQ(2)) dut (
        .clk_i                  (clk),
        .rst_ni                 (rst_n),
        .req_valid_i            (req_valid),
        .req_ready_o            (req_ready),
        .req_i                  (req),
`ifdef VLSU_ARB_LOCK_EN
        .req_lock_i             (req_lock),
`endif
        .xif_mem_valid_o        (xif_valid),
        .xif_mem_ready_i        (xif_ready),
        .xif_mem_req_o          (xif_req),
        .xif_mem_result_valid_i (xres_valid),
        .xif_mem_result_i       (xres),
        .res_valid_o            (res_valid),
        .res_o                  (res),
        .err_orphan_o           (orphan),
        .dbg_state_o            (dbg_state)
    );

    // ---------------------------------------------------------------- bookkeeping
    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_q[$];

    localparam int NONE = 2;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // ---------------------------------------------------------------- drivers
    task automatic set_req(input int r, input logic v, input logic [3:0] id);
        req_valid[r]  = v;
        req[r].id     = id;
        req[r].addr   = 32'hA000_0000 + (r << 16) + {28'd0, id};
        req[r].mode   = 2'b01;
        req[r].we     = r[0];
        req[r].be     = 4'hF;
        req[r].wdata  = 32'h5500_0000 + (r << 8) + {28'd0, id};
    endtask

    task automatic drive_result(input logic v, input logic [3:0] id,
                                input logic [31:0] rdata, input logic expect_hit);
        xres_valid = v;
        xres.id    = id;
        xres.rdata = rdata;
        xres.err   = 1'b0;
        if (v && expect_hit) exp_q.push_back(rdata);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
    endtask

    // ---------------------------------------------------------------- checkers
    task automatic check_req(input string tag, input int gnt, input logic [1:0] rdy);
        x_mem_req_t exp_req;
        exp_req = '0;
        if (gnt == 0) exp_req = req[0];
        if (gnt == 1) exp_req = req[1];
        chk({tag, ".xif_valid"}, {127'd0, xif_valid}, {127'd0, gnt != NONE});
        chk({tag, ".req_ready"}, {126'd0, req_ready}, {126'd0, rdy});
        chk({tag, ".xif_req"},   {53'd0, xif_req},   {53'd0, exp_req});
    endtask

    task automatic check_res(input string tag, input logic [1:0] exp_res, input logic exp_orph);
        logic [31:0] e;
        chk({tag, ".res_valid"}, {126'd0, res_valid}, {126'd0, exp_res});
        chk({tag, ".orphan"},    {127'd0, orphan},    {127'd0, exp_orph});
        if (res_valid != 2'b00) begin
            if (exp_q.size() == 0) begin
                chk({tag, ".sb_underflow"}, 128'd1, 128'd0);
            end else begin
                e = exp_q.pop_front();
                chk({tag, ".rdata"}, {96'd0, res[res_valid[1]].rdata}, {96'd0, e});
            end
        end
    endtask

    task automatic check_state(input string tag, input logic [1:0] st);
        chk({tag, ".state"}, {126'd0, dbg_state}, {126'd0, st});
    endtask

    // ---------------------------------------------------------------- vector table
    typedef struct {
        logic [1:0] valid;
        logic [3:0] id0;
        logic [3:0] id1;
        logic       rdy;
        logic       rv;
        logic [3:0] rid;
        int         gnt;
        logic [1:0] exp_rdy;
        logic [1:0] exp_res;
        logic       exp_orph;
        logic [1:0] exp_state;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs[NV];

    function automatic vec_t mk(input logic [1:0] valid, input logic [3:0] id0, input logic [3:0] id1,
                                input logic rdy, input logic rv, input logic [3:0] rid,
                                input int gnt, input logic [1:0] exp_rdy, input logic [1:0] exp_res,
                                input logic exp_orph, input logic [1:0] exp_state);
        vec_t v;
        v.valid = valid; v.id0 = id0; v.id1 = id1; v.rdy = rdy; v.rv = rv; v.rid = rid;
        v.gnt = gnt; v.exp_rdy = exp_rdy; v.exp_res = exp_res; v.exp_orph = exp_orph;
        v.exp_state = exp_state;
        return v;
    endfunction

    // ---------------------------------------------------------------- test
    initial begin
        //                valid  id0 id1 rdy rv rid  gnt   rdy    res    orph st
        vecs[0]  = mk(2'b11, 1, 2, 1, 0, 0, 0,    2'b01, 2'b00, 0, 0);
        vecs[1]  = mk(2'b11, 3, 2, 1, 0, 0, 1,    2'b10, 2'b00, 0, 0);
        vecs[2]  = mk(2'b11, 4, 5, 1, 0, 0, 0,    2'b01, 2'b00, 0, 0);
        vecs[3]  = mk(2'b10, 0, 2, 1, 1, 1, NONE, 2'b00, 2'b01, 0, 0);
        vecs[4]  = mk(2'b10, 0, 2, 1, 1, 2, NONE, 2'b00, 2'b10, 0, 0);
        vecs[5]  = mk(2'b10, 0, 2, 1, 1, 9, 1,    2'b10, 2'b00, 1, 0);
        vecs[6]  = mk(2'b01, 4, 0, 1, 1, 4, NONE, 2'b00, 2'b01, 0, 0);
        vecs[7]  = mk(2'b01, 4, 0, 0, 0, 0, 0,    2'b00, 2'b00, 0, 0);
        vecs[8]  = mk(2'b11, 4, 6, 0, 0, 0, 0,    2'b00, 2'b00, 0, 1);
        vecs[9]  = mk(2'b11, 4, 6, 1, 0, 0, 0,    2'b01, 2'b00, 0, 1);
        vecs[10] = mk(2'b11, 7, 6, 1, 0, 0, 1,    2'b10, 2'b00, 0, 0);
        vecs[11] = mk(2'b00, 0, 0, 1, 1, 6, NONE, 2'b00, 2'b10, 0, 0);
        vecs[12] = mk(2'b00, 0, 0, 1, 1, 4, NONE, 2'b00, 2'b01, 0, 0);
        vecs[13] = mk(2'b00, 0, 0, 1, 1, 2, NONE, 2'b00, 2'b10, 0, 0);
        vecs[14] = mk(2'b01, 1, 0, 0, 0, 0, 0,    2'b00, 2'b00, 0, 0);
        vecs[15] = mk(2'b10, 1, 3, 1, 0, 0, NONE, 2'b00, 2'b00, 0, 1);
        vecs[16] = mk(2'b10, 1, 3, 1, 0, 0, 1,    2'b10, 2'b00, 0, 0);
        vecs[17] = mk(2'b00, 0, 0, 1, 1, 3, NONE, 2'b00, 2'b10, 0, 0);

        // Idle inputs
        rst_n = 1'b0;
        set_req(0, 1'b0, 4'd0);
        set_req(1, 1'b0, 4'd0);
        xif_ready = 1'b0;
        drive_result(1'b0, 4'd0, 32'd0, 1'b0);
`ifdef VLSU_ARB_LOCK_EN
        req_lock = 2'b00;
`endif
        next_cycle();

        // ---- reset with active inputs: all outputs idle
        set_req(0, 1'b1, 4'd1);
        set_req(1, 1'b1, 4'd2);
        xif_ready = 1'b1;
        drive_result(1'b1, 4'd1, 32'h1111_1111, 1'b0);
        next_cycle();
        #2;
        check_req("rst", NONE, 2'b00);
        check_res("rst", 2'b00, 1'b0);
        check_state("rst", 2'd0);
        next_cycle();
        rst_n = 1'b1;
        set_req(0, 1'b0, 4'd0);
        set_req(1, 1'b0, 4'd0);
        drive_result(1'b0, 4'd0, 32'd0, 1'b0);

        // ---- table-driven vectors
        for (int i = 0; i < NV; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            set_req(0, vecs[i].valid[0], vecs[i].id0);
            set_req(1, vecs[i].valid[1], vecs[i].id1);
            xif_ready = vecs[i].rdy;
            drive_result(vecs[i].rv, vecs[i].rid, 32'hC0DE_0000 + i,
                         vecs[i].exp_res != 2'b00);
            #2;
            check_state(tag, vecs[i].exp_state);
            check_req(tag, vecs[i].gnt, vecs[i].exp_rdy);
            check_res(tag, vecs[i].exp_res, vecs[i].exp_orph);
            next_cycle();
        end
        set_req(0, 1'b0, 4'd0);
        set_req(1, 1'b0, 4'd0);
        drive_result(1'b0, 4'd0, 32'd0, 1'b0);

        // ---- alternating round robin from reset, fresh IDs each beat
        do_reset();
        xif_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            set_req(0, 1'b1, 4'(1 + 2 * ((k + 1) / 2)));
            set_req(1, 1'b1, 4'(2 + 2 * (k / 2)));
            #2;
            check_req($sformatf("rr%0d", k), k % 2, (k % 2) ? 2'b10 : 2'b01);
            next_cycle();
        end

        // ---- reset with outstanding IDs: old results become orphans
        rst_n = 1'b0;
        #2;
        check_req("rst_mid", NONE, 2'b00);
        next_cycle();
        rst_n = 1'b1;
        set_req(0, 1'b0, 4'd0);
        set_req(1, 1'b0, 4'd0);
        drive_result(1'b1, 4'd1, 32'h2222_2222, 1'b0);
        #2;
        check_res("post_rst_orphan", 2'b00, 1'b1);
        next_cycle();
        drive_result(1'b0, 4'd0, 32'd0, 1'b0);

        // ---- stall: grant stays on req0, payload stable
        set_req(0, 1'b1, 4'd3);
        set_req(1, 1'b1, 4'd5);
        xif_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #2;
            check_req($sformatf("stall%0d", k), 0, 2'b00);
            chk($sformatf("stall%0d.addr", k), {96'd0, xif_req.addr}, {96'd0, 32'hA000_0003});
            check_state($sformatf("stall%0d", k), (k == 0) ? 2'd0 : 2'd1);
            next_cycle();
        end
        xif_ready = 1'b1;
        #2;
        check_req("stall_hs", 0, 2'b01);
        next_cycle();
        set_req(0, 1'b0, 4'd3);
        #2;
        check_req("after_stall", 1, 2'b10);
        next_cycle();
        set_req(1, 1'b0, 4'd5);

        // ---- result for req0 ID 3
        drive_result(1'b1, 4'd3, 32'hDEAD_BEEF, 1'b1);
        #2;
        check_res("res_id3", 2'b01, 1'b0);
        next_cycle();
        drive_result(1'b0, 4'd0, 32'd0, 1'b0);

        // ---- ID hazard on req1 (ID 5 outstanding)
        set_req(1, 1'b1, 4'd5);
        for (int k = 0; k < 2; k++) begin
            #2;
            check_req($sformatf("hazard%0d", k), NONE, 2'b00);
            next_cycle();
        end
        drive_result(1'b1, 4'd5, 32'h0000_0505, 1'b1);
        #2;
        check_req("hazard_res", NONE, 2'b00);
        check_res("hazard_res", 2'b10, 1'b0);
        next_cycle();
        drive_result(1'b0, 4'd0, 32'd0, 1'b0);
        #2;
        check_req("hazard_clear", 1, 2'b10);
        next_cycle();
        set_req(1, 1'b0, 4'd0);

        // ---- orphan ID 7: one-cycle pulse; ID 3 was cleared and reissues
        drive_result(1'b1, 4'd7, 32'h0000_0707, 1'b0);
        set_req(0, 1'b1, 4'd3);
        #2;
        check_res("orphan7", 2'b00, 1'b1);
        check_req("reissue3", 0, 2'b01);
        next_cycle();
        drive_result(1'b0, 4'd0, 32'd0, 1'b0);
        set_req(0, 1'b0, 4'd0);
        #2;
        check_res("orphan_end", 2'b00, 1'b0);
        next_cycle();

`ifdef VLSU_ARB_LOCK_EN
        // ---- 8-beat locked burst on req0, req1 waiting throughout
        do_reset();
        xif_ready = 1'b1;
        set_req(1, 1'b1, 4'd1);
        for (int b = 0; b < 8; b++) begin
            set_req(0, 1'b1, 4'(8 + b));
            req_lock = {1'b0, b < 7};
            #2;
            check_req($sformatf("burst%0d", b), 0, 2'b01);
            check_state($sformatf("burst%0d", b), (b == 0) ? 2'd0 : 2'd1);
            next_cycle();
        end
        set_req(0, 1'b0, 4'd0);
        req_lock = 2'b00;
        #2;
        check_req("burst_done", 1, 2'b10);
        next_cycle();

        // ---- reset in the middle of a locked burst
        do_reset();
        set_req(1, 1'b1, 4'd2);
        for (int b = 0; b < 3; b++) begin
            set_req(0, 1'b1, 4'(b));
            req_lock = 2'b01;
            next_cycle();
        end
        rst_n = 1'b0;
        #2;
        check_req("burst_rst", NONE, 2'b00);
        next_cycle();
        #2;
        check_state("burst_rst", 2'd0);
        check_res("burst_rst", 2'b00, 1'b0);
        rst_n = 1'b1;
        set_req(0, 1'b0, 4'd0);
        set_req(1, 1'b0, 4'd0);
        req_lock = 2'b00;
        next_cycle();
`endif

        chk("sb_empty", 128'(exp_q.size()), 128'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Hard stop in case something stalls the sequence
    initial begin
        #200000;
        $display("FAIL timeout: actual running required finished");
        $fatal(1, "timeout");
    end

endmodule
